sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter that shares one asynchronous SRAM among PORTS
//   requesters. Each granted transaction runs IDLE -> SETUP -> ACCESS
//   (WAIT_CYCLES+1 cycles) -> DONE, and the winner gets a one-cycle ack
//   in DONE.
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   req/we            : per-port level request and write enable
//   addr/wdata        : per-port address / write data, port i in slice i
//   ack               : one-cycle completion pulse per port
//   rdata             : data of the most recent completed read
//   busy              : high while a transaction is in flight
//   memDataBus        : bidirectional SRAM data bus
//   memAddrBus        : SRAM address
//   memRead/memWrite/memEnable : active-low SRAM strobes
module sram_arbiter #(
  parameter int PORTS       = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         req,
  input  logic [PORTS-1:0]         we,
  input  logic [PORTS*ADDR_W-1:0]  addr,
  input  logic [PORTS*DATA_W-1:0]  wdata,
  output logic [PORTS-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  inout  wire  [DATA_W-1:0]        memDataBus,
  output logic [ADDR_W-1:0]        memAddrBus,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     memEnable
);

  localparam int PW = $clog2(PORTS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic              drive_bus;

  // Round-robin search starting at ptr_q. Scanning offsets from high to
  // low lets the lowest offset (closest to the pointer) win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (req[PW'((int'(ptr_q) + k) % PORTS)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr_q) + k) % PORTS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_SETUP;
          win_d   = gnt_idx;
          we_d    = we[gnt_idx];
          addr_d  = addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d = wdata[gnt_idx*DATA_W +: DATA_W];
          ptr_d   = PW'((int'(gnt_idx) + 1) % PORTS);
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 4'd0;
      end
      S_ACCESS: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = S_DONE;
          // Read data is captured on the last edge the read strobe is low.
          if (!we_q) begin
            rdata_d = memDataBus;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset releases the strobes and the bus in the same cycle.
  always_comb begin
    ack = '0;
    if (state_q == S_DONE) begin
      ack[win_q] = 1'b1;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign memEnable  = !((state_q == S_SETUP) || (state_q == S_ACCESS));
  assign memRead    = !((state_q == S_ACCESS) && !we_q);
  assign memWrite   = !((state_q == S_ACCESS) && we_q);
  assign memAddrBus = addr_q;
  assign rdata      = rdata_q;

  assign drive_bus  = we_q && ((state_q == S_SETUP) || (state_q == S_ACCESS));
  assign memDataBus = drive_bus ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int P  = 4;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WC = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [P-1:0]    req = '0;
  logic [P-1:0]    we  = '0;
  logic [P*AW-1:0] addr  = '0;
  logic [P*DW-1:0] wdata = '0;
  wire  [P-1:0]    ack;
  wire  [DW-1:0]   rdata;
  wire             busy;
  wire  [DW-1:0]   memDataBus;
  wire  [AW-1:0]   memAddrBus;
  wire             memRead, memWrite, memEnable;

  // Two-port builds with the extreme wait settings.
  logic [1:0]  reqA = '0, reqB = '0;
  wire  [1:0]  ackA, ackB;
  wire  [15:0] rdataA, rdataB, busA, busB;
  wire  [17:0] abA, abB;
  wire         busyA, busyB, rdA, rdB, wrA, wrB, enA, enB;

  always #5 clk = ~clk;

  sram_arbiter #(.PORTS(P), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .memDataBus(memDataBus),
    .memAddrBus(memAddrBus), .memRead(memRead), .memWrite(memWrite),
    .memEnable(memEnable));

  sram_arbiter #(.PORTS(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req(reqA), .we(2'b00), .addr({18'h0, 18'h22}),
    .wdata(32'h0), .ack(ackA), .rdata(rdataA), .busy(busyA),
    .memDataBus(busA), .memAddrBus(abA), .memRead(rdA), .memWrite(wrA),
    .memEnable(enA));

  sram_arbiter #(.PORTS(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .req(reqB), .we(2'b00), .addr({18'h0, 18'h22}),
    .wdata(32'h0), .ack(ackB), .rdata(rdataB), .busy(busyB),
    .memDataBus(busB), .memAddrBus(abB), .memRead(rdB), .memWrite(wrB),
    .memEnable(enB));

  // SRAM model: read data is a fixed function of the address; the bus is
  // held at 16'h5A5A while the chip is deselected so an unexpected DUT
  // driver shows up as a different value.
  function automatic logic [15:0] pat(input logic [17:0] a);
    return (a == 18'h10) ? 16'hBEEF : (a[15:0] ^ 16'h1357);
  endfunction

  assign memDataBus = memEnable ? 16'h5A5A : (!memRead ? pat(memAddrBus) : 16'hzzzz);
  assign busA = (!enA && !rdA) ? 16'hC0DE : 16'hzzzz;
  assign busB = (!enB && !rdB) ? 16'hC0DE : 16'hzzzz;

  logic [17:0] wr_a = '0;
  logic [15:0] wr_d = '0;
  always @(posedge clk) begin
    if (!memEnable && !memWrite) begin
      wr_a <= memAddrBus;
      wr_d <= memDataBus;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_rd = '0;

  // Scoreboard consumer: every ack must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && ack != '0) begin
      if (sb.size() == 0) begin
        chk_val("ack_unexpected", 32'(ack), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk_val("ack_port", 32'(ack), 32'(1) << mon_e.port);
        chk_val("ack_rdata", 32'(rdata), 32'(mon_e.rd));
      end
    end
  end

  function automatic exp_t mk(input int p, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.rd   = d;
    return e;
  endfunction

  task automatic drive_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    req[p] = 1'b1;
    we[p]  = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int c;
    int wid;
    c = 0;
    wid = 0;
    if (!w) model_rd = pat(a);
    sb.push_back(mk(p, model_rd));
    drive_port(p, w, a, d);
    do begin
      @(negedge clk);
      c++;
      if (!memRead || !memWrite) wid++;
      if (c == 1) chk_val("setup_addr", 32'(memAddrBus), 32'(a));
      if (w && !memEnable) chk_val("wr_bus", 32'(memDataBus), 32'(d));
    end while (!ack[p] && c < 60);
    chk_val("ack_latency", 32'(c), 32'(WC + 3));
    chk_val("strobe_width", 32'(wid), 32'(WC + 1));
    if (w) chk_val("done_bus_released", 32'(memDataBus), 32'h5A5A);
    req[p] = 1'b0;
  endtask

  task automatic wait_ack(input int p, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[p] && n < 60);
    chk_val(tag, 32'(ack[p]), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_rd = '0;
    @(negedge clk);
  endtask

  initial begin
    int c, n_ack, last, latA, latB, wA, wB;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_ack", 32'(ack), 32'(0));
    chk_val("rst_busy", 32'(busy), 32'(0));
    chk_val("rst_strobes", 32'({memRead, memWrite, memEnable}), 32'(3'b111));
    chk_val("rst_addr", 32'(memAddrBus), 32'(0));
    chk_val("rst_rdata", 32'(rdata), 32'(0));
    chk_val("rst_bus", 32'(memDataBus), 32'h5A5A);
    rst = 1'b1;
    @(negedge clk);

    // Single read and single write
    do_txn(0, 1'b0, 18'h00010, 16'h0000);
    chk_val("read_rdata", 32'(rdata), 32'hBEEF);
    @(negedge clk);
    do_txn(1, 1'b1, 18'h3FFFF, 16'h1234);
    @(negedge clk);
    chk_val("write_mem_addr", 32'(wr_a), 32'h3FFFF);
    chk_val("write_mem_data", 32'(wr_d), 32'h1234);
    chk_val("write_keeps_rdata", 32'(rdata), 32'hBEEF);

    // All four ports requesting continuously after a fresh reset
    do_reset();
    for (int i = 0; i < P; i++) drive_port(i, 1'b0, 18'(18'h100 + i), 16'h0);
    for (int i = 0; i < 8; i++) begin
      model_rd = pat(18'(18'h100 + (i % P)));
      sb.push_back(mk(i % P, model_rd));
    end
    n_ack = 0;
    c = 0;
    last = 0;
    while (n_ack < 8 && c < 200) begin
      @(negedge clk);
      c++;
      if (ack != '0) begin
        n_ack++;
        if (n_ack == 1) chk_val("rr_first_latency", 32'(c), 32'(WC + 3));
        else chk_val("rr_gap", 32'(c - last), 32'(WC + 4));
        last = c;
        if (n_ack == 8) req = '0;
      end
    end
    chk_val("rr_ack_count", 32'(n_ack), 32'(8));
    req = '0;
    @(negedge clk);

    // Port 2 withdraws before being granted; port 3 is served next
    model_rd = pat(18'h20);
    sb.push_back(mk(0, model_rd));
    drive_port(0, 1'b0, 18'h20, 16'h0);
    repeat (2) @(negedge clk);
    drive_port(2, 1'b1, 18'h28, 16'h2222);
    drive_port(3, 1'b1, 18'h30, 16'h7777);
    sb.push_back(mk(3, model_rd));
    @(negedge clk);
    req[2] = 1'b0;
    wait_ack(0, "withdraw_ack0");
    req[0] = 1'b0;
    wait_ack(3, "withdraw_ack3");
    req[3] = 1'b0;
    repeat (12) @(negedge clk);
    chk_val("withdraw_mem_addr", 32'(wr_a), 32'h30);
    chk_val("withdraw_mem_data", 32'(wr_d), 32'h7777);

    // Reset during the access phase of a write
    drive_port(1, 1'b1, 18'h40, 16'hABCD);
    repeat (2) @(negedge clk);
    chk_val("abort_in_access", 32'(memWrite), 32'(0));
    #2 rst = 1'b0;
    #1;
    chk_val("abort_strobes", 32'({memRead, memWrite, memEnable}), 32'(3'b111));
    chk_val("abort_bus", 32'(memDataBus), 32'h5A5A);
    chk_val("abort_busy", 32'(busy), 32'(0));
    chk_val("abort_ack", 32'(ack), 32'(0));
    chk_val("abort_rdata", 32'(rdata), 32'(0));
    model_rd = '0;
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    model_rd = pat(18'h50);
    sb.push_back(mk(0, model_rd));
    model_rd = pat(18'h51);
    sb.push_back(mk(1, model_rd));
    drive_port(0, 1'b0, 18'h50, 16'h0);
    drive_port(1, 1'b0, 18'h51, 16'h0);
    wait_ack(0, "post_reset_ack0");
    req[0] = 1'b0;
    wait_ack(1, "post_reset_ack1");
    req[1] = 1'b0;
    repeat (4) @(negedge clk);

    // Extreme wait settings, single read each
    latA = 0; latB = 0; wA = 0; wB = 0;
    reqA[0] = 1'b1;
    reqB[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!rdA) wA++;
      if (!rdB) wB++;
      if (ackA[0] && latA == 0) begin latA = k; reqA[0] = 1'b0; end
      if (ackB[0] && latB == 0) begin latB = k; reqB[0] = 1'b0; end
    end
    chk_val("w0_latency", 32'(latA), 32'(3));
    chk_val("w0_strobe_width", 32'(wA), 32'(1));
    chk_val("w0_rdata", 32'(rdataA), 32'hC0DE);
    chk_val("w15_latency", 32'(latB), 32'(18));
    chk_val("w15_strobe_width", 32'(wB), 32'(16));
    chk_val("w15_rdata", 32'(rdataB), 32'hC0DE);
    chk_val("wx_idle", 32'({busyA, busyB, wrA, wrB}), 32'(4'b0011));
    chk_val("wx_addr", 32'({abA, abB}), 32'({18'h22, 18'h22}));
    chk_val("wx_ack_idle", 32'({ackA, ackB}), 32'(0));

    chk_val("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
